// File: rtl/change_return_unit_pkg.sv
// Shared constants and types for the change/credit stage.
// Coin values and item prices live here so the dispenser and this block
// always agree on them.
package change_return_unit_pkg;

  localparam int kNumItems  = 4;
  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 31;

  typedef logic [kTotalBits-1:0] amount_t;
  // One extra bit so that balance + inserted coins can be tested for overflow.
  typedef logic [kTotalBits:0]   wide_amount_t;
  typedef logic [kNumCoins-1:0]  coin_vec_t;
  typedef logic [kNumItems-1:0]  item_vec_t;

  // Ascending order. The coin selector relies on this.
  localparam amount_t COIN_VALUE [kNumCoins] = '{
    amount_t'(100), amount_t'(500), amount_t'(1000)
  };

  localparam amount_t ITEM_PRICE [kNumItems] = '{
    amount_t'(400), amount_t'(500), amount_t'(1000), amount_t'(2000)
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RETURN
  } state_e;

  // Total value of every coin bit that is set this cycle.
  function automatic wide_amount_t coin_sum(input coin_vec_t coins);
    wide_amount_t sum;
    sum = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (coins[i]) sum = sum + {1'b0, COIN_VALUE[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/change_return_unit_if.sv
// Front-panel / dispenser side signals of the change return unit.
interface change_return_unit_if;
  import change_return_unit_pkg::*;

  coin_vec_t i_input_coin;
  logic      i_trigger_return;
  amount_t   item_cost;
  amount_t   balance;
  item_vec_t o_available_item;
  coin_vec_t o_return_coin;
  logic      o_busy;

  // The change return unit itself.
  modport slave (
    input  i_input_coin, i_trigger_return, item_cost,
    output balance, o_available_item, o_return_coin, o_busy
  );

  // Whatever drives coins, return requests and sales into the unit.
  modport master (
    output i_input_coin, i_trigger_return, item_cost,
    input  balance, o_available_item, o_return_coin, o_busy
  );

endinterface

// File: rtl/change_return_unit_coin_selector.sv
// Combinational: picks the largest coin that does not exceed the balance.
// Returns a one-hot coin vector and its value; both are zero when the
// balance is below the smallest coin.
module change_return_unit_coin_selector
  import change_return_unit_pkg::*;
(
  input  amount_t   balance,
  output coin_vec_t coin,
  output amount_t   value
);

  // Scan ascending denominations; the last one that fits is the largest.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    coin  = '0;
    value = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (balance >= COIN_VALUE[i]) begin
        coin    = '0;
        coin[i] = 1'b1;
        value   = COIN_VALUE[i];
      end
    end
  end

endmodule

// File: rtl/change_return_unit.sv
// Balance/credit stage in front of the item dispenser. Accepts coins,
// debits sales, and on request or inactivity pays the balance back as
// change, one coin per cycle, largest denomination first.
module change_return_unit
  import change_return_unit_pkg::*;
#(
  parameter int WAIT_TIME = 10
) (
  input  logic clk,
  input  logic reset,
  change_return_unit_if.slave bus
);

  localparam int TIMER_W = (WAIT_TIME > 0) ? $clog2(WAIT_TIME + 1) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(WAIT_TIME);

  state_e             state;
  amount_t            balance;
  logic [TIMER_W-1:0] timer;

  wide_amount_t credit;
  wide_amount_t sum_wide;
  amount_t      sum_sat;
  amount_t      balance_next;
  logic         activity;

  coin_vec_t sel_coin;
  amount_t   sel_value;
  item_vec_t available;

  change_return_unit_coin_selector u_coin_selector (
    .balance (balance),
    .coin    (sel_coin),
    .value   (sel_value)
  );

  // Credit/debit arithmetic for ACTIVE: saturating add, clamp-to-zero debit.
  always_comb begin
    credit   = coin_sum(bus.i_input_coin);
    sum_wide = {1'b0, balance} + credit;
    sum_sat  = sum_wide[kTotalBits] ? '1 : sum_wide[kTotalBits-1:0];
    // The dispenser never charges more than the balance; if it does, the
    // customer keeps nothing rather than the counter wrapping.
    balance_next = (bus.item_cost > sum_sat) ? '0 : sum_sat - bus.item_cost;
    activity     = (credit != '0) || (bus.item_cost != '0);
  end

  // Main FSM: state, balance and inactivity timer.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state   <= ST_IDLE;
      balance <= '0;
      timer   <= TIMER_RELOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          // Return requests are meaningless with nothing to return.
          if (credit != '0) begin
            balance <= credit[kTotalBits-1:0];
            state   <= ST_ACTIVE;
            timer   <= TIMER_RELOAD;
          end
        end

        ST_ACTIVE: begin
          balance <= balance_next;
          if (balance_next == '0) begin
            state <= ST_IDLE;
            timer <= TIMER_RELOAD;
          end else if (bus.i_trigger_return) begin
            state <= ST_RETURN;
            timer <= TIMER_RELOAD;
          end else if (activity) begin
            timer <= TIMER_RELOAD;
          end else if (timer == '0) begin
            state <= ST_RETURN;
            timer <= TIMER_RELOAD;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        ST_RETURN: begin
          // Coins, sales and return requests are all ignored while paying.
          if (sel_value == '0) begin
            // Either fully paid, or a sub-100 residue that cannot be paid.
            balance <= '0;
            state   <= ST_IDLE;
          end else begin
            balance <= balance - sel_value;
          end
        end

        default: begin
          state   <= ST_IDLE;
          balance <= '0;
          timer   <= TIMER_RELOAD;
        end
      endcase
    end
  end

  // Item availability from the registered balance; nothing is sellable while paying.
  always_comb begin
    available = '0;
    for (int i = 0; i < kNumItems; i++) begin
      available[i] = (state != ST_RETURN) && (balance >= ITEM_PRICE[i]);
    end
  end

  assign bus.balance          = balance;
  assign bus.o_available_item = available;
  assign bus.o_busy           = (state == ST_RETURN);
  assign bus.o_return_coin    = (state == ST_RETURN) ? sel_coin : '0;

endmodule

// File: tb/tb_change_return_unit.sv
// Self-checking bench for change_return_unit. Expected payout coins are
// queued when a return is provoked and popped as the DUT pays them.
module tb_change_return_unit;
  import change_return_unit_pkg::*;

  localparam int WAIT_TIME = 10;

  logic clk;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_coin_q [$];

  change_return_unit_if bus ();

  change_return_unit #(.WAIT_TIME(WAIT_TIME)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every coin paid must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.o_return_coin != '0) begin
      if (exp_coin_q.size() == 0) begin
        check("coin_unexpected", 64'(bus.o_return_coin), 64'd0);
      end else begin
        check("coin_order", 64'(bus.o_return_coin), 64'(exp_coin_q.pop_front()));
      end
    end
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Cycle until the unit leaves RETURN, bounded by a cycle budget.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.o_busy && n < budget) begin
      cycle();
      n++;
    end
    check("wait_idle_timeout", 64'(bus.o_busy), 64'd0);
  endtask

  // Expect exactly WAIT_TIME+1 quiet edges before RETURN begins.
  task automatic expect_timeout(input string tag);
    for (int i = 0; i < WAIT_TIME; i++) begin
      cycle();
      check({tag, "_busy_early"}, 64'(bus.o_busy), 64'd0);
    end
    cycle();
    check({tag, "_busy_timeout"}, 64'(bus.o_busy), 64'd1);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      check(tag, {bus.balance, bus.o_available_item, bus.o_return_coin, bus.o_busy}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    bus.i_input_coin     = '0;
    bus.i_trigger_return = 1'b0;
    bus.item_cost        = '0;
    cycle();
    cycle();
    check("reset_outputs", {bus.balance, bus.o_available_item, bus.o_return_coin, bus.o_busy}, 64'd0);
    reset = 1'b0;

    // Idle after reset: everything stays zero.
    quiet("idle_after_reset", 20);

    // 1000 then 500, no sale, timeout payout 1000 + 500.
    bus.i_input_coin = 3'b100;
    cycle();
    check("t2_bal_1000", 64'(bus.balance), 64'd1000);
    bus.i_input_coin = 3'b010;
    cycle();
    bus.i_input_coin = '0;
    check("t2_bal_1500", 64'(bus.balance), 64'd1500);
    check("t2_avail", 64'(bus.o_available_item), 64'b0111);
    exp_coin_q.push_back(3'b100);
    exp_coin_q.push_back(3'b010);
    expect_timeout("t2");
    check("t2_avail_locked", 64'(bus.o_available_item), 64'd0);
    wait_idle(20);
    check("t2_bal_final", 64'(bus.balance), 64'd0);
    check("t2_coins_left", 64'(exp_coin_q.size()), 64'd0);

    // Sale and coin in the same cycle; timer reloads.
    bus.i_input_coin = 3'b100;
    cycle();
    bus.i_input_coin = 3'b001;
    bus.item_cost    = 31'd400;
    cycle();
    bus.i_input_coin = '0;
    bus.item_cost    = '0;
    check("t3_bal_700", 64'(bus.balance), 64'd700);
    check("t3_avail", 64'(bus.o_available_item), 64'b0011);
    exp_coin_q.push_back(3'b010);
    exp_coin_q.push_back(3'b001);
    exp_coin_q.push_back(3'b001);
    expect_timeout("t3");
    wait_idle(20);
    check("t3_bal_final", 64'(bus.balance), 64'd0);
    check("t3_coins_left", 64'(exp_coin_q.size()), 64'd0);

    // Exact-price sale drops straight to IDLE with no change.
    bus.i_input_coin = 3'b010;
    cycle();
    bus.i_input_coin = '0;
    bus.item_cost    = 31'd500;
    cycle();
    bus.item_cost = '0;
    check("t4_bal_zero", 64'(bus.balance), 64'd0);
    check("t4_busy", 64'(bus.o_busy), 64'd0);
    quiet("t4_stays_idle", 15);

    // Overcharge clamps to zero.
    bus.i_input_coin = 3'b010;
    cycle();
    bus.i_input_coin = '0;
    bus.item_cost    = 31'd1000;
    cycle();
    bus.item_cost = '0;
    check("clamp_bal", 64'(bus.balance), 64'd0);
    check("clamp_busy", 64'(bus.o_busy), 64'd0);

    // Return request in IDLE is ignored.
    bus.i_trigger_return = 1'b1;
    cycle();
    bus.i_trigger_return = 1'b0;
    check("idle_trigger_ignored", 64'(bus.o_busy), 64'd0);

    // 1800 with explicit return; a 500 inserted mid-payout is lost.
    bus.i_input_coin = 3'b111;
    cycle();
    check("t5_bal_1600", 64'(bus.balance), 64'd1600);
    bus.i_input_coin = 3'b001;
    cycle();
    cycle();
    bus.i_input_coin = '0;
    check("t5_bal_1800", 64'(bus.balance), 64'd1800);
    check("t5_avail", 64'(bus.o_available_item), 64'b0111);
    exp_coin_q.push_back(3'b100);
    exp_coin_q.push_back(3'b010);
    exp_coin_q.push_back(3'b001);
    exp_coin_q.push_back(3'b001);
    exp_coin_q.push_back(3'b001);
    bus.i_trigger_return = 1'b1;
    cycle();
    bus.i_trigger_return = 1'b0;
    check("t5_busy", 64'(bus.o_busy), 64'd1);
    check("t5_avail_locked", 64'(bus.o_available_item), 64'd0);
    bus.i_input_coin = 3'b010;
    cycle();
    bus.i_input_coin = '0;
    check("t5_coin_not_credited", 64'(bus.balance), 64'd800);
    wait_idle(20);
    check("t5_bal_final", 64'(bus.balance), 64'd0);
    check("t5_coins_left", 64'(exp_coin_q.size()), 64'd0);

    // Asynchronous reset in the middle of a payout discards the rest.
    bus.i_input_coin = 3'b110;
    cycle();
    bus.i_input_coin = '0;
    check("t6_bal_1500", 64'(bus.balance), 64'd1500);
    exp_coin_q.push_back(3'b100);
    bus.i_trigger_return = 1'b1;
    cycle();
    bus.i_trigger_return = 1'b0;
    cycle();
    check("t6_bal_500", 64'(bus.balance), 64'd500);
    check("t6_coin_500", 64'(bus.o_return_coin), 64'b010);
    #1 reset = 1'b1;
    #1;
    check("t6_async_clear", {bus.balance, bus.o_available_item, bus.o_return_coin, bus.o_busy}, 64'd0);
    cycle();
    cycle();
    reset = 1'b0;
    quiet("t6_after_reset", 15);
    check("t6_coins_left", 64'(exp_coin_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
